qpu_exu_lsuagu_q: RTL and testbench

Parametrised load/store address-generation unit with a decoupling command queue. It sits between the EXU dispatch stage and LSU-ctrl. It computes `rs1 + imm`, sizes byte/half/word/dword accesses, and generates lane-aligned write data and byte masks. Misaligned accesses are diverted to an exception port. Program order is kept across both output ports by an internal DEPTH-entry FIFO.

---
 rtl/qpu_exu_lsuagu_q.sv | 165 ++++++++++++++++
 tb/tb_qpu_exu_lsuagu_q.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_lsuagu_q.sv
// Load/store address-generation unit: computes rs1+imm, builds lane-aligned
// store data and byte masks, and queues ops in program order toward LSU-ctrl or the misalign port.
module qpu_exu_lsuagu_q #(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int ITAG_WIDTH = 4,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    agu_i_valid,
    output logic                    agu_i_ready,
    input  logic                    agu_i_load,
    input  logic                    agu_i_store,
    input  logic [1:0]              agu_i_size,
    input  logic [XLEN-1:0]         agu_i_rs1,
    input  logic [11:0]             agu_i_imm,
    input  logic [XLEN-1:0]         agu_i_rs2,
    input  logic [ITAG_WIDTH-1:0]   agu_i_itag,
    output logic                    agu_i_longpipe,
    output logic                    agu_icb_cmd_valid,
    input  logic                    agu_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0]    agu_icb_cmd_addr,
    output logic                    agu_icb_cmd_read,
    output logic [XLEN-1:0]         agu_icb_cmd_wdata,
    output logic [XLEN/8-1:0]       agu_icb_cmd_wmask,
    output logic [ITAG_WIDTH-1:0]   agu_icb_cmd_itag,
    output logic                    agu_excp_valid,
    input  logic                    agu_excp_ready,
    output logic                    agu_excp_ld,
    output logic [ADDR_SIZE-1:0]    agu_excp_badaddr,
    output logic [ITAG_WIDTH-1:0]   agu_excp_itag
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  read;
        logic [ADDR_SIZE-1:0]  addr;
        logic [XLEN-1:0]       wdata;
        logic [NB-1:0]         wmask;
        logic [ITAG_WIDTH-1:0] itag;
        logic                  mis;
    } entry_t;

    logic [XLEN-1:0] ea_full;
    logic [OFFW-1:0] off;
    logic [7:0]      mask_base;
    entry_t          new_entry;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic            empty_q, empty_d;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic            push, pop;

    // Address, alignment, byte mask and lane-replicated store data for the issuing op.
    always_comb begin
        ea_full   = agu_i_rs1 + {{(XLEN-12){agu_i_imm[11]}}, agu_i_imm};
        off       = ea_full[OFFW-1:0];
        new_entry = '0;
        case (agu_i_size)
            2'd0: begin
                mask_base     = 8'h01;
                new_entry.mis = 1'b0;
            end
            2'd1: begin
                mask_base     = 8'h03;
                new_entry.mis = ea_full[0];
            end
            2'd2: begin
                mask_base     = 8'h0F;
                new_entry.mis = |ea_full[1:0];
            end
            default: begin
                // A doubleword cannot fit a 32-bit lane set at all.
                mask_base     = 8'hFF;
                new_entry.mis = (XLEN == 32) | (|ea_full[2:0]);
            end
        endcase
        new_entry.read  = agu_i_load;
        new_entry.addr  = ea_full[ADDR_SIZE-1:0];
        new_entry.itag  = agu_i_itag;
        new_entry.wmask = NB'(mask_base << off);
        for (int i = 0; i < NB; i++) begin
            case (agu_i_size)
                2'd0:    new_entry.wdata[i*8 +: 8] = agu_i_rs2[7:0];
                2'd1:    new_entry.wdata[i*8 +: 8] = agu_i_rs2[(i % 2)*8 +: 8];
                2'd2:    new_entry.wdata[i*8 +: 8] = agu_i_rs2[(i % 4)*8 +: 8];
                default: new_entry.wdata[i*8 +: 8] = agu_i_rs2[(i % 8)*8 +: 8];
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign push = agu_i_valid & ready_q & (agu_i_load | agu_i_store);
    assign pop  = (~empty_q & ~head.mis & agu_icb_cmd_ready) |
                  (~empty_q &  head.mis & agu_excp_ready);

    // Queue pointer/occupancy next state; flush drops everything including a same-cycle push.
    always_comb begin
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Queue control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    // Entry payload storage; not reset since valid is tracked by count.
    always_ff @(posedge clk) begin
        if (push & ~flush) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign agu_i_ready       = ready_q;
    assign agu_i_longpipe    = agu_i_load | agu_i_store;

    assign agu_icb_cmd_valid = ~empty_q & ~head.mis;
    assign agu_icb_cmd_addr  = head.addr;
    assign agu_icb_cmd_read  = head.read;
    assign agu_icb_cmd_wdata = head.wdata;
    assign agu_icb_cmd_wmask = head.wmask;
    assign agu_icb_cmd_itag  = head.itag;

    assign agu_excp_valid    = ~empty_q & head.mis;
    assign agu_excp_ld       = head.read;
    assign agu_excp_badaddr  = head.addr;
    assign agu_excp_itag     = head.itag;

endmodule

// File: tb/tb_qpu_exu_lsuagu_q.sv
// Directed bench for qpu_exu_lsuagu_q: a scoreboard of expected queue entries
// is filled on issue and drained by a negedge monitor on each output handshake.
module tb_qpu_exu_lsuagu_q;

    logic clk = 1'b0;
    logic rst, flush;

    logic        d_valid, d_ready, d_load, d_store, d_longpipe;
    logic [1:0]  d_size;
    logic [31:0] d_rs1, d_rs2;
    logic [11:0] d_imm;
    logic [3:0]  d_itag;
    logic        d_cmd_valid, d_cmd_ready, d_cmd_read;
    logic [31:0] d_cmd_addr, d_cmd_wdata;
    logic [3:0]  d_cmd_wmask, d_cmd_itag;
    logic        d_excp_valid, d_excp_ready, d_excp_ld;
    logic [31:0] d_excp_badaddr;
    logic [3:0]  d_excp_itag;

    logic        e_valid, e_ready, e_load, e_store, e_longpipe;
    logic [1:0]  e_size;
    logic [63:0] e_rs1, e_rs2;
    logic [11:0] e_imm;
    logic [3:0]  e_itag;
    logic        e_cmd_valid, e_cmd_ready, e_cmd_read;
    logic [31:0] e_cmd_addr;
    logic [63:0] e_cmd_wdata;
    logic [7:0]  e_cmd_wmask;
    logic [3:0]  e_cmd_itag;
    logic        e_excp_valid, e_excp_ready, e_excp_ld;
    logic [31:0] e_excp_badaddr;
    logic [3:0]  e_excp_itag;

    qpu_exu_lsuagu_q #(.XLEN(32), .ADDR_SIZE(32), .ITAG_WIDTH(4), .DEPTH(2)) u_d (
        .clk(clk), .rst(rst), .flush(flush),
        .agu_i_valid(d_valid), .agu_i_ready(d_ready), .agu_i_load(d_load),
        .agu_i_store(d_store), .agu_i_size(d_size), .agu_i_rs1(d_rs1),
        .agu_i_imm(d_imm), .agu_i_rs2(d_rs2), .agu_i_itag(d_itag),
        .agu_i_longpipe(d_longpipe),
        .agu_icb_cmd_valid(d_cmd_valid), .agu_icb_cmd_ready(d_cmd_ready),
        .agu_icb_cmd_addr(d_cmd_addr), .agu_icb_cmd_read(d_cmd_read),
        .agu_icb_cmd_wdata(d_cmd_wdata), .agu_icb_cmd_wmask(d_cmd_wmask),
        .agu_icb_cmd_itag(d_cmd_itag),
        .agu_excp_valid(d_excp_valid), .agu_excp_ready(d_excp_ready),
        .agu_excp_ld(d_excp_ld), .agu_excp_badaddr(d_excp_badaddr),
        .agu_excp_itag(d_excp_itag)
    );

    qpu_exu_lsuagu_q #(.XLEN(64), .ADDR_SIZE(32), .ITAG_WIDTH(4), .DEPTH(2)) u_e (
        .clk(clk), .rst(rst), .flush(flush),
        .agu_i_valid(e_valid), .agu_i_ready(e_ready), .agu_i_load(e_load),
        .agu_i_store(e_store), .agu_i_size(e_size), .agu_i_rs1(e_rs1),
        .agu_i_imm(e_imm), .agu_i_rs2(e_rs2), .agu_i_itag(e_itag),
        .agu_i_longpipe(e_longpipe),
        .agu_icb_cmd_valid(e_cmd_valid), .agu_icb_cmd_ready(e_cmd_ready),
        .agu_icb_cmd_addr(e_cmd_addr), .agu_icb_cmd_read(e_cmd_read),
        .agu_icb_cmd_wdata(e_cmd_wdata), .agu_icb_cmd_wmask(e_cmd_wmask),
        .agu_icb_cmd_itag(e_cmd_itag),
        .agu_excp_valid(e_excp_valid), .agu_excp_ready(e_excp_ready),
        .agu_excp_ld(e_excp_ld), .agu_excp_badaddr(e_excp_badaddr),
        .agu_excp_itag(e_excp_itag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic        read;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [3:0]  itag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   bad    = 0;
    int   pushes = 0;
    int   pops   = 0;
    int   w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one issued op, written from the address/mask/data definitions.
    function automatic exp_t model(input logic ld, input logic [1:0] size, input logic [63:0] rs1,
                                   input logic [11:0] imm, input logic [63:0] rs2,
                                   input logic [3:0] itag, input int xlen);
        exp_t        m;
        logic [63:0] ea;
        int          nb, lanes, off;
        ea = rs1 + {{52{imm[11]}}, imm};
        if (xlen == 32) ea[63:32] = 32'h0;
        nb    = 1 << size;
        lanes = xlen / 8;
        off   = int'(ea % 64'(lanes));
        m.mis   = ((ea % 64'(nb)) != 64'h0) || (size == 2'd3 && xlen == 32);
        m.read  = ld;
        m.addr  = ea[31:0];
        m.itag  = itag;
        m.wmask = 8'h0;
        m.wdata = 64'h0;
        for (int j = 0; j < lanes; j++) begin
            if (j >= off && j < off + nb) m.wmask[j] = 1'b1;
            m.wdata[j*8 +: 8] = rs2[(j % nb)*8 +: 8];
        end
        return m;
    endfunction

    task automatic issue(input logic ld, input logic st, input logic [1:0] size,
                         input logic [31:0] rs1, input logic [11:0] imm,
                         input logic [31:0] rs2, input logic [3:0] itag, output int waited);
        bit acc = 1'b0;
        d_valid = 1'b1; d_load = ld; d_store = st; d_size = size;
        d_rs1 = rs1; d_imm = imm; d_rs2 = rs2; d_itag = itag;
        #1;
        chk("longpipe", d_longpipe, ld | st);
        waited = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = d_ready;
            if (acc && (ld || st)) begin
                sb.push_back(model(ld, size, {32'h0, rs1}, imm, {32'h0, rs2}, itag, 32));
                pushes++;
            end
            @(posedge clk); #1;
            waited++;
        end
        d_valid = 1'b0;
        chk("issue_accept", acc, 1'b1);
    endtask

    task automatic drain();
        d_cmd_ready  = 1'b1;
        d_excp_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_cmd_valid", d_cmd_valid, 1'b0);
        chk("drain_excp_valid", d_excp_valid, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ((d_cmd_valid && d_cmd_ready) || (d_excp_valid && d_excp_ready))) begin
            chk("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                pops++;
                if (d_cmd_valid) begin
                    chk("cmd_port_sel", 1'b0, mon_e.mis);
                    chk("cmd_addr", d_cmd_addr, mon_e.addr);
                    chk("cmd_read", d_cmd_read, mon_e.read);
                    chk("cmd_wdata", {32'h0, d_cmd_wdata}, mon_e.wdata);
                    chk("cmd_wmask", {4'h0, d_cmd_wmask}, mon_e.wmask);
                    chk("cmd_itag", d_cmd_itag, mon_e.itag);
                end else begin
                    chk("excp_port_sel", 1'b1, mon_e.mis);
                    chk("excp_ld", d_excp_ld, mon_e.read);
                    chk("excp_badaddr", d_excp_badaddr, mon_e.addr);
                    chk("excp_itag", d_excp_itag, mon_e.itag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        d_valid = 1'b0; d_load = 1'b0; d_store = 1'b0; d_size = 2'd0;
        d_rs1 = 32'h0; d_imm = 12'h0; d_rs2 = 32'h0; d_itag = 4'h0;
        d_cmd_ready = 1'b0; d_excp_ready = 1'b0;
        e_valid = 1'b0; e_load = 1'b0; e_store = 1'b0; e_size = 2'd0;
        e_rs1 = 64'h0; e_imm = 12'h0; e_rs2 = 64'h0; e_itag = 4'h0;
        e_cmd_ready = 1'b0; e_excp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("rst_ready", d_ready, 1'b1);
        chk("rst_cmd_valid", d_cmd_valid, 1'b0);
        chk("rst_excp_valid", d_excp_valid, 1'b0);
        chk("rst_e_ready", e_ready, 1'b1);

        // Byte store: 0x1000 + 3.
        issue(1'b0, 1'b1, 2'd0, 32'h1000, 12'd3, 32'h12345678, 4'd1, w);
        chk("bs_valid", d_cmd_valid, 1'b1);
        chk("bs_addr", d_cmd_addr, 32'h1003);
        chk("bs_wdata", d_cmd_wdata, 32'h78787878);
        chk("bs_wmask", d_cmd_wmask, 4'b1000);
        chk("bs_read", d_cmd_read, 1'b0);
        d_cmd_ready = 1'b1; tick(); d_cmd_ready = 1'b0;
        chk("bs_gone", d_cmd_valid, 1'b0);

        // Halfword load with negative offset.
        issue(1'b1, 1'b0, 2'd1, 32'h2004, 12'hFFE, 32'hCAFEF00D, 4'd2, w);
        chk("hl_addr", d_cmd_addr, 32'h2002);
        chk("hl_read", d_cmd_read, 1'b1);
        chk("hl_wmask", d_cmd_wmask, 4'b1100);
        drain();

        // Op with neither load nor store is accepted but never queued.
        d_cmd_ready = 1'b0;
        issue(1'b0, 1'b0, 2'd2, 32'h7000, 12'd0, 32'h0, 4'd15, w);
        chk("nop_no_cmd", d_cmd_valid, 1'b0);
        chk("nop_no_excp", d_excp_valid, 1'b0);

        // Misaligned word store blocks a younger aligned load.
        d_cmd_ready = 1'b1; d_excp_ready = 1'b0;
        issue(1'b0, 1'b1, 2'd2, 32'h1000, 12'd2, 32'hDEADBEEF, 4'd3, w);
        chk("mis_excp_valid", d_excp_valid, 1'b1);
        chk("mis_excp_ld", d_excp_ld, 1'b0);
        chk("mis_badaddr", d_excp_badaddr, 32'h1002);
        issue(1'b1, 1'b0, 2'd2, 32'h3000, 12'd0, 32'h0, 4'd4, w);
        chk("mis_block_cmd", d_cmd_valid, 1'b0);
        chk("mis_full", d_ready, 1'b0);
        tick();
        chk("mis_still_block", d_cmd_valid, 1'b0);
        chk("mis_hold_excp", d_excp_valid, 1'b1);
        d_excp_ready = 1'b1; tick(); d_excp_ready = 1'b0;
        chk("mis_after_excp", d_excp_valid, 1'b0);
        chk("mis_load_out", d_cmd_valid, 1'b1);
        chk("mis_load_addr", d_cmd_addr, 32'h3000);
        drain();

        // Backpressure: two fill the queue, third waits for the first pop.
        d_cmd_ready = 1'b0;
        issue(1'b1, 1'b0, 2'd2, 32'h4000, 12'd0, 32'h0, 4'd5, w);
        issue(1'b0, 1'b1, 2'd1, 32'h4010, 12'd6, 32'hA5A5BEEF, 4'd6, w);
        chk("bp_not_ready", d_ready, 1'b0);
        chk("bp_head_itag", d_cmd_itag, 4'd5);
        d_cmd_ready = 1'b1;
        issue(1'b1, 1'b0, 2'd0, 32'h4020, 12'hFFF, 32'h0, 4'd7, w);
        chk("bp_ready_return", w, 2);
        chk("bp_third_head", d_cmd_itag, 4'd7);
        drain();

        // Flush with a simultaneous pop and push.
        d_cmd_ready = 1'b0;
        issue(1'b0, 1'b1, 2'd2, 32'h5000, 12'd4, 32'h11223344, 4'd8, w);
        flush = 1'b1; d_cmd_ready = 1'b1;
        d_valid = 1'b1; d_load = 1'b1; d_store = 1'b0; d_size = 2'd2;
        d_rs1 = 32'h5100; d_imm = 12'd0; d_itag = 4'd9;
        tick();
        flush = 1'b0; d_valid = 1'b0; d_cmd_ready = 1'b0;
        pushes -= sb.size(); sb.delete();
        chk("fl_cmd_valid", d_cmd_valid, 1'b0);
        chk("fl_excp_valid", d_excp_valid, 1'b0);
        chk("fl_ready", d_ready, 1'b1);
        tick();
        chk("fl_push_absent", d_cmd_valid, 1'b0);

        // Flush of a full queue with no handshake.
        issue(1'b1, 1'b0, 2'd0, 32'h5200, 12'd1, 32'h0, 4'd10, w);
        issue(1'b1, 1'b0, 2'd0, 32'h5200, 12'd2, 32'h0, 4'd11, w);
        chk("fl2_full", d_ready, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        pushes -= sb.size(); sb.delete();
        chk("fl2_ready", d_ready, 1'b1);
        chk("fl2_cmd_valid", d_cmd_valid, 1'b0);

        // Doubleword on a 32-bit datapath always traps.
        d_excp_ready = 1'b0;
        issue(1'b1, 1'b0, 2'd3, 32'h8, 12'd0, 32'h0, 4'd12, w);
        chk("d32_excp", d_excp_valid, 1'b1);
        chk("d32_ld", d_excp_ld, 1'b1);
        chk("d32_badaddr", d_excp_badaddr, 32'h8);
        drain();

        // Throughput with both output readies held high.
        for (int i = 0; i < 6; i++) begin
            issue(i[0], ~i[0], 2'(i % 3), 32'h6000 + 32'(i * 8), 12'(i * 2),
                  $urandom, 4'(i), w);
            chk("thru_one_cycle", w, 1);
        end
        drain();

        // XLEN 64 instance.
        e_valid = 1'b1; e_store = 1'b1; e_load = 1'b0; e_size = 2'd3;
        e_rs1 = 64'h8; e_imm = 12'd0; e_rs2 = 64'h1122334455667788; e_itag = 4'd1;
        tick(); e_valid = 1'b0;
        chk("x64_d_valid", e_cmd_valid, 1'b1);
        chk("x64_d_addr", e_cmd_addr, 32'h8);
        chk("x64_d_wmask", e_cmd_wmask, 8'hFF);
        chk("x64_d_wdata", e_cmd_wdata, 64'h1122334455667788);
        e_cmd_ready = 1'b1; tick(); e_cmd_ready = 1'b0;
        chk("x64_d_gone", e_cmd_valid, 1'b0);
        e_valid = 1'b1; e_store = 1'b0; e_load = 1'b1; e_rs1 = 64'h4; e_itag = 4'd2;
        tick(); e_valid = 1'b0;
        chk("x64_mis_excp", e_excp_valid, 1'b1);
        chk("x64_mis_cmd", e_cmd_valid, 1'b0);
        chk("x64_mis_badaddr", e_excp_badaddr, 32'h4);
        e_excp_ready = 1'b1; tick(); e_excp_ready = 1'b0;
        chk("x64_mis_gone", e_excp_valid, 1'b0);
        e_valid = 1'b1; e_store = 1'b1; e_load = 1'b0; e_size = 2'd0;
        e_rs1 = 64'h1000; e_imm = 12'd5; e_rs2 = 64'h00000000000000AB; e_itag = 4'd3;
        tick(); e_valid = 1'b0;
        chk("x64_b_addr", e_cmd_addr, 32'h1005);
        chk("x64_b_wmask", e_cmd_wmask, 8'h20);
        chk("x64_b_wdata", e_cmd_wdata, 64'hABABABABABABABAB);
        e_cmd_ready = 1'b1; tick(); e_cmd_ready = 1'b0;

        chk("final_sb_empty", sb.size(), 0);
        chk("final_pop_count", pops, pushes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
